// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the riscv_fetch front end.
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault_fetch;
      logic        fault_page;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-unit bus bundle: branch redirect, icache request/response, and fetch->decode output.
interface riscv_fetch_if;

   logic        branch_request_i;
   logic [31:0] branch_pc_i;
   logic        icache_accept_i;
   logic        icache_valid_i;
   logic [31:0] icache_inst_i;
   logic        icache_error_i;
   logic        icache_page_fault_i;
   logic        fetch_accept_i;
   logic        icache_rd_o;
   logic [31:0] icache_pc_o;
   logic        fetch_valid_o;
   logic [31:0] fetch_instr_o;
   logic [31:0] fetch_pc_o;
   logic        fetch_fault_fetch_o;
   logic        fetch_fault_page_o;
   logic        squash_decode_o;

   modport master (
      input  branch_request_i, branch_pc_i, icache_accept_i, icache_valid_i,
             icache_inst_i, icache_error_i, icache_page_fault_i, fetch_accept_i,
      output icache_rd_o, icache_pc_o, fetch_valid_o, fetch_instr_o, fetch_pc_o,
             fetch_fault_fetch_o, fetch_fault_page_o, squash_decode_o
   );

   modport slave (
      output branch_request_i, branch_pc_i, icache_accept_i, icache_valid_i,
             icache_inst_i, icache_error_i, icache_page_fault_i, fetch_accept_i,
      input  icache_rd_o, icache_pc_o, fetch_valid_o, fetch_instr_o, fetch_pc_o,
             fetch_fault_fetch_o, fetch_fault_page_o, squash_decode_o
   );

endinterface

// File: rtl/riscv_fetch_slot.sv
// Output register toward decode; RISCV_FETCH_SKID_EN adds a one-entry skid behind it.
module riscv_fetch_slot
   import riscv_fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load,
   input  fetch_entry_t entry_in,
   input  logic         accept,
   input  logic         flush,
   output logic         valid,
   output fetch_entry_t entry_out,
   output logic         ready
);

   logic         out_valid_q;
   fetch_entry_t out_q;

`ifdef RISCV_FETCH_SKID_EN
   logic         skid_valid_q;
   fetch_entry_t skid_q;
   logic         out_free;

   assign out_free = !out_valid_q || accept;
   assign ready    = !skid_valid_q;

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (!rst_ni || flush) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_q        <= skid_q;
            skid_valid_q <= load;
            if (load) skid_q <= entry_in;
         end else begin
            out_valid_q <= load;
            if (load) out_q <= entry_in;
         end
      end else if (load) begin
         skid_valid_q <= 1'b1;
         skid_q       <= entry_in;
      end
   end
`else
   assign ready = !out_valid_q || accept;

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (!rst_ni || flush) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_q       <= entry_in;
      end else if (accept) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   assign valid     = out_valid_q;
   assign entry_out = out_q;

endmodule

// File: rtl/riscv_fetch.sv
// Sequential instruction fetch with one outstanding icache read, redirect and fault halt.
// Optional skid buffer in the output slot: define RISCV_FETCH_SKID_EN.
module riscv_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
   input logic           clk_i,
   input logic           rst_ni,
   riscv_fetch_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         drop_q, drop_d;
   logic         rd, load, resp_fault;
   logic         slot_ready, slot_valid;
   fetch_entry_t resp_entry, out_entry;

   assign rd = rst_ni && (state_q == FETCH) && slot_ready && !bus.branch_request_i;
   assign resp_fault = bus.icache_error_i || bus.icache_page_fault_i;

   // Only one read is in flight and a redirect always drops it, so its address is pc_q - 4.
   assign resp_entry = '{
      instr:       resp_fault ? 32'h0 : bus.icache_inst_i,
      pc:          pc_q - PC_INC,
      fault_fetch: bus.icache_error_i,
      fault_page:  bus.icache_page_fault_i
   };

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= FETCH;
         pc_q    <= BOOT_VECTOR;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      // NOTE: every signal of this block gets a default first, so no path infers a latch.
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      load    = 1'b0;
      if (bus.branch_request_i) begin
         pc_d = {bus.branch_pc_i[31:2], 2'b00};
         if (state_q == WAIT && !bus.icache_valid_i) begin
            drop_d = 1'b1;
         end else begin
            state_d = FETCH;
            drop_d  = 1'b0;
         end
      end else begin
         unique case (state_q)
            FETCH: begin
               if (rd && bus.icache_accept_i) begin
                  pc_d    = pc_q + PC_INC;
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.icache_valid_i) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = FETCH;
                  end else begin
                     load    = 1'b1;
                     state_d = resp_fault ? HALT : FETCH;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   riscv_fetch_slot u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load      (load),
      .entry_in  (resp_entry),
      .accept    (bus.fetch_accept_i),
      .flush     (bus.branch_request_i),
      .valid     (slot_valid),
      .entry_out (out_entry),
      .ready     (slot_ready)
   );

   assign bus.icache_rd_o         = rd;
   assign bus.icache_pc_o         = pc_q;
   assign bus.fetch_valid_o       = slot_valid;
   assign bus.fetch_instr_o       = out_entry.instr;
   assign bus.fetch_pc_o          = out_entry.pc;
   assign bus.fetch_fault_fetch_o = out_entry.fault_fetch;
   assign bus.fetch_fault_page_o  = out_entry.fault_page;
   assign bus.squash_decode_o     = bus.branch_request_i;

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: latency table, directed corner cases, random run vs. a queue model.
module tb_riscv_fetch;
   import riscv_fetch_pkg::*;

   localparam logic [31:0] BOOT  = 32'h8000_0000;
   localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   riscv_fetch_if bus ();

   riscv_fetch #(.BOOT_VECTOR(BOOT)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   // icache responder
   bit          pend = 0;
   int          pend_cnt = 0;
   logic [31:0] pend_pc = '0;
   int          resp_lat = 1;
   bit          rand_lat = 0;
   bit          rand_faults = 0;
   logic [31:0] pf_pc  = 32'h1;
   logic [31:0] err_pc = 32'h1;

   // reference model: every accepted request in the current epoch, oldest first
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ff;
      logic        fp;
   } exp_t;
   exp_t        exp_q[$];
   logic [31:0] exp_req_pc = BOOT;
   bit          halted = 0;
   bit          outstanding = 0;

   // per-cycle snapshot and history
   logic        s_rd, s_valid, s_ff, s_fp;
   logic [31:0] s_ipc, s_pc, s_instr;
   logic        prev_rd = 0, prev_iacc = 0, prev_valid = 0, prev_facc = 0, prev_br = 0;
   logic [31:0] prev_ipc = '0, prev_pc = '0, prev_instr = '0;
   int          req_cnt = 0, del_cnt = 0;
   logic [31:0] last_req_pc = '0, last_del_pc = '0, last_del_instr = '0;
   logic        last_del_ff = 0, last_del_fp = 0;

   typedef struct {
      logic        f_acc;
      logic        i_acc;
      logic        rd;
      logic [31:0] ipc;
      logic        valid;
      logic [31:0] pc;
   } vec_t;
   vec_t vecs[7];

   function automatic bit pf_at(input logic [31:0] pc);
      return (pc == pf_pc) || (rand_faults && pc[7:2] == 6'h2D);
   endfunction

   function automatic bit err_at(input logic [31:0] pc);
      return (pc == err_pc) || (rand_faults && pc[7:2] == 6'h13);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: sample and score at the falling edge, then drive the responder after the rising edge.
   task automatic cycle();
      exp_t        e;
      logic [31:0] a;
      @(negedge clk_i);
      s_rd    = bus.icache_rd_o;
      s_ipc   = bus.icache_pc_o;
      s_valid = bus.fetch_valid_o;
      s_pc    = bus.fetch_pc_o;
      s_instr = bus.fetch_instr_o;
      s_ff    = bus.fetch_fault_fetch_o;
      s_fp    = bus.fetch_fault_page_o;
      check("squash", bus.squash_decode_o, bus.branch_request_i);
      if (!rst_ni) begin
         exp_q.delete();
         exp_req_pc  = BOOT;
         halted      = 0;
         outstanding = 0;
      end else begin
         if (prev_rd && !prev_iacc && !bus.branch_request_i) begin
            check("rd_held", s_rd, 1);
            check("rd_pc_held", s_ipc, prev_ipc);
         end
         if (prev_valid && !prev_facc && !prev_br) begin
            check("out_valid_held", s_valid, 1);
            check("out_pc_held", s_pc, prev_pc);
            check("out_instr_held", s_instr, prev_instr);
         end
         if (s_rd && bus.icache_accept_i) begin
            req_cnt++;
            last_req_pc = s_ipc;
            check("req_pc", s_ipc, exp_req_pc);
            check("req_one_outstanding", outstanding, 0);
            check("req_after_fault", halted, 0);
            a       = exp_req_pc;
            e.pc    = a;
            e.ff    = err_at(a);
            e.fp    = pf_at(a);
            e.instr = (e.ff || e.fp) ? 32'h0 : (a ^ MAGIC);
            exp_q.push_back(e);
            halted      = e.ff || e.fp;
            outstanding = 1;
            exp_req_pc  = a + 32'd4;
         end
         if (s_valid && bus.fetch_accept_i && !bus.branch_request_i) begin
            del_cnt++;
            last_del_pc    = s_pc;
            last_del_instr = s_instr;
            last_del_ff    = s_ff;
            last_del_fp    = s_fp;
            check("del_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("del_pc", s_pc, e.pc);
               check("del_instr", s_instr, e.instr);
               check("del_fault_fetch", s_ff, e.ff);
               check("del_fault_page", s_fp, e.fp);
            end
         end
         if (bus.branch_request_i) begin
            exp_q.delete();
            exp_req_pc = {bus.branch_pc_i[31:2], 2'b00};
            halted     = 0;
         end
      end
      if (bus.icache_valid_i) outstanding = 0;
      if (s_rd && bus.icache_accept_i && !pend) begin
         pend     = 1;
         pend_pc  = s_ipc;
         pend_cnt = rand_lat ? int'($urandom_range(1, 3)) : resp_lat;
      end
      prev_rd    = rst_ni && s_rd;
      prev_iacc  = bus.icache_accept_i;
      prev_ipc   = s_ipc;
      prev_valid = rst_ni && s_valid;
      prev_facc  = bus.fetch_accept_i;
      prev_br    = bus.branch_request_i;
      prev_pc    = s_pc;
      prev_instr = s_instr;
      @(posedge clk_i);
      #1;
      bus.icache_valid_i      = 1'b0;
      bus.icache_inst_i       = 32'h0;
      bus.icache_error_i      = 1'b0;
      bus.icache_page_fault_i = 1'b0;
      if (pend) begin
         if (pend_cnt <= 1) begin
            bus.icache_valid_i      = 1'b1;
            bus.icache_inst_i       = pend_pc ^ MAGIC;
            bus.icache_error_i      = err_at(pend_pc);
            bus.icache_page_fault_i = pf_at(pend_pc);
            pend = 0;
         end else begin
            pend_cnt--;
         end
      end
   endtask

   task automatic do_reset();
      bus.icache_accept_i = 1'b0;
      rst_ni = 1'b0;
      cycle();
      cycle();
      for (int i = 0; i < 5 && pend; i++) cycle();
      rst_ni = 1'b1;
      bus.icache_accept_i = 1'b1;
   endtask

   task automatic wait_req_pc(input logic [31:0] pc, input string what);
      bit hit = 0;
      int c0;
      for (int i = 0; i < 40 && !hit; i++) begin
         c0 = req_cnt;
         cycle();
         if (req_cnt != c0 && last_req_pc == pc) hit = 1;
      end
      check(what, hit, 1);
   endtask

   task automatic wait_del_pc(input logic [31:0] pc, input string what);
      bit hit = 0;
      int c0;
      for (int i = 0; i < 40 && !hit; i++) begin
         c0 = del_cnt;
         cycle();
         if (del_cnt != c0 && last_del_pc == pc) hit = 1;
      end
      check(what, hit, 1);
   endtask

   task automatic branch_to(input logic [31:0] target);
      bus.branch_request_i = 1'b1;
      bus.branch_pc_i      = target;
      cycle();
      bus.branch_request_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, d0;
      vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0008, 1'b0, 32'h0};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_000C, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};

      bus.branch_request_i    = 1'b0;
      bus.branch_pc_i         = 32'h0;
      bus.icache_accept_i     = 1'b0;
      bus.icache_valid_i      = 1'b0;
      bus.icache_inst_i       = 32'h0;
      bus.icache_error_i      = 1'b0;
      bus.icache_page_fault_i = 1'b0;
      bus.fetch_accept_i      = 1'b1;

      // reset state, observed in the second reset cycle
      cycle();
      cycle();
      check("rst_rd", s_rd, 0);
      check("rst_icache_pc", s_ipc, BOOT);
      check("rst_valid", s_valid, 0);
      check("rst_instr", s_instr, 0);
      check("rst_pc", s_pc, 0);
      check("rst_faults", {s_ff, s_fp}, 0);
      rst_ni = 1'b1;

      // latency and throughput with a 1-cycle icache and no backpressure
      foreach (vecs[i]) begin
         bus.fetch_accept_i  = vecs[i].f_acc;
         bus.icache_accept_i = vecs[i].i_acc;
         cycle();
         check($sformatf("tbl%0d_rd", i), s_rd, vecs[i].rd);
         check($sformatf("tbl%0d_icache_pc", i), s_ipc, vecs[i].ipc);
         check($sformatf("tbl%0d_valid", i), s_valid, vecs[i].valid);
         if (vecs[i].valid) begin
            check($sformatf("tbl%0d_pc", i), s_pc, vecs[i].pc);
            check($sformatf("tbl%0d_instr", i), s_instr, vecs[i].pc ^ MAGIC);
         end
      end

      // decode backpressure while 8000_0004 is on the output
      do_reset();
      for (int i = 0; i < 20 && !(bus.fetch_valid_o && bus.fetch_pc_o == 32'h8000_0004); i++) cycle();
      check("bp_reached", bus.fetch_valid_o && bus.fetch_pc_o == 32'h8000_0004, 1);
      bus.fetch_accept_i = 1'b0;
      c0 = req_cnt;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_valid", s_valid, 1);
         check("bp_pc", s_pc, 32'h8000_0004);
         check("bp_instr", s_instr, 32'h8000_0004 ^ MAGIC);
`ifndef RISCV_FETCH_SKID_EN
         check("bp_no_rd", s_rd, 0);
`endif
      end
`ifdef RISCV_FETCH_SKID_EN
      check("bp_skid_req_count", req_cnt - c0, 1);
      check("bp_skid_req_pc", last_req_pc, 32'h8000_0008);
`else
      check("bp_req_count", req_cnt - c0, 0);
`endif
      bus.fetch_accept_i = 1'b1;
      d0 = del_cnt;
      wait_del_pc(32'h8000_0004, "bp_release_first");
      check("bp_release_first_is_next", del_cnt - d0, 1);
      wait_del_pc(32'h8000_0008, "bp_release_second");
      check("bp_release_second_is_next", del_cnt - d0, 2);

      // redirect while a 2-cycle read is outstanding
      resp_lat = 2;
      do_reset();
      wait_req_pc(32'h8000_0008, "br_req_0008");
      bus.branch_request_i = 1'b1;
      bus.branch_pc_i      = 32'h0000_1002;
      cycle();
      check("br_squash_on", s_squash_snapshot(), 1);
      bus.branch_request_i = 1'b0;
      cycle();
      check("br_squash_off", s_squash_snapshot(), 0);
      c0 = req_cnt;
      wait_req_pc(32'h0000_1000, "br_next_req_1000");
      check("br_first_req_after", req_cnt - c0, 1);
      wait_del_pc(32'h0000_1000, "br_del_1000");

      // page fault halts fetching until a redirect
      resp_lat = 1;
      pf_pc    = 32'h8000_000C;
      do_reset();
      wait_del_pc(32'h8000_000C, "pf_del");
      check("pf_fault_page", last_del_fp, 1);
      check("pf_fault_fetch", last_del_ff, 0);
      check("pf_instr", last_del_instr, 0);
      c0 = req_cnt;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("pf_halt_no_rd", s_rd, 0);
      end
      check("pf_halt_req_count", req_cnt - c0, 0);
      err_pc = 32'h0000_2004;
      branch_to(32'h0000_2000);
      wait_req_pc(32'h0000_2000, "pf_resume_2000");

      // bus error, then a redirect in the same cycle as a response
      wait_del_pc(32'h0000_2004, "err_del");
      check("err_fault_fetch", last_del_ff, 1);
      check("err_fault_page", last_del_fp, 0);
      check("err_instr", last_del_instr, 0);
      branch_to(32'h0000_3000);
      wait_req_pc(32'h0000_3000, "err_req_3000");
      d0 = del_cnt;
      branch_to(32'h0000_4000);
      cycle();
      check("same_cycle_drop_rd", s_rd, 1);
      check("same_cycle_drop_pc", s_ipc, 32'h0000_4000);
      check("same_cycle_drop_no_del", del_cnt - d0, 0);

      // reset while waiting; the late response must be ignored
      resp_lat = 3;
      wait_req_pc(32'h0000_4004, "rw_req");
      rst_ni = 1'b0;
      bus.icache_accept_i = 1'b0;
      cycle();
      rst_ni = 1'b1;
      d0 = del_cnt;
      cycle();
      check("rw_valid", s_valid, 0);
      check("rw_icache_pc", s_ipc, BOOT);
      check("rw_instr", s_instr, 0);
      for (int i = 0; i < 6; i++) cycle();
      check("rw_late_resp_gone", pend, 0);
      check("rw_no_del", del_cnt - d0, 0);
      bus.icache_accept_i = 1'b1;
      c0 = req_cnt;
      wait_req_pc(BOOT, "rw_req_boot");
      check("rw_first_req", req_cnt - c0, 1);
      wait_del_pc(BOOT, "rw_del_boot");

      // PC wraps from FFFF_FFFC to 0
      resp_lat = 1;
      branch_to(32'hFFFF_FFFA);
      wait_req_pc(32'hFFFF_FFF8, "wrap_fff8");
      wait_req_pc(32'hFFFF_FFFC, "wrap_fffc");
      wait_req_pc(32'h0000_0000, "wrap_0000");

      // random traffic against the model
      pf_pc       = 32'h1;
      err_pc      = 32'h1;
      rand_faults = 1;
      rand_lat    = 1;
      d0 = del_cnt;
      for (int i = 0; i < 3000; i++) begin
         bus.icache_accept_i  = ($urandom_range(0, 9) < 7);
         bus.fetch_accept_i   = ($urandom_range(0, 9) < 6);
         bus.branch_request_i = ($urandom_range(0, 99) < 3);
         bus.branch_pc_i      = $urandom_range(0, 1023);
         cycle();
      end
      bus.branch_request_i = 1'b0;
      bus.icache_accept_i  = 1'b1;
      bus.fetch_accept_i   = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      check("random_progress", del_cnt - d0 > 200, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   function automatic logic s_squash_snapshot();
      return prev_br;
   endfunction

endmodule
